// File: rtl/omem_acc_writer_pkg.sv
// Shared definitions for the OMEM accumulate writer: FSM encoding,
// OMEM read/write strobe values and default lane geometry.
package omem_acc_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  localparam logic OMEM_RD = 1'b0;
  localparam logic OMEM_WR = 1'b1;

  localparam int DEF_LANES  = 4;
  localparam int DEF_LANE_W = 16;
  localparam int ADDR_W     = 4;
  localparam int WCNT_W     = 5;

endpackage

// File: rtl/omem_acc_writer_lane_add.sv
// One lane of the accumulator: LANE_W-bit two's-complement add with signed
// overflow detection and optional clipping to the signed range.
module lane_add #(
  parameter int LANE_W = 16,
  parameter int SAT    = 0
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
  output logic [LANE_W-1:0] sum,
  output logic              ovf
);

  logic [LANE_W-1:0] raw;
  logic [LANE_W-1:0] clip;

  // Overflow: operands agree in sign but the truncated result does not.
  always_comb begin
    raw  = a + b;
    ovf  = (a[LANE_W-1] == b[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);
    clip = a[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    sum  = ((SAT != 0) && ovf) ? clip : raw;
  end

endmodule

// File: rtl/omem_acc_writer.sv
// Writes result rows into OMEM, either overwriting or read-modify-write
// accumulating lane-wise. One row in flight at a time, so consecutive rows
// to the same address never race.
module omem_acc_writer
  import omem_acc_writer_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int SAT    = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDR_W-1:0]       in_addr,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic                    in_acc,
  input  logic                    in_last,
  output logic                    en_o,
  output logic                    rw_o,
  output logic [ADDR_W-1:0]       addr_o,
  output logic [LANES*LANE_W-1:0] wdata_o,
  input  logic [LANES*LANE_W-1:0] rdata_o,
  output logic                    done,
  output logic [WCNT_W-1:0]       wcnt,
  output logic                    ovf
);

  localparam int W = LANES * LANE_W;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] hold_addr;
  logic [W-1:0]      hold_data;
  logic              hold_acc;
  logic              hold_last;
  logic [W-1:0]      sum_word;
  logic [LANES-1:0]  lane_ovf;
  logic              accept;
  logic              in_wr;
  logic              wr_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_add #(.LANE_W(LANE_W), .SAT(SAT)) u_lane_add (
      .a   (rdata_o[i*LANE_W +: LANE_W]),
      .b   (hold_data[i*LANE_W +: LANE_W]),
      .sum (sum_word[i*LANE_W +: LANE_W]),
      .ovf (lane_ovf[i])
    );
  end

  // Ready only while idle and out of reset, so reset forces it low.
  assign in_ready = (state_q == ST_IDLE) && !rstn;
  assign accept   = in_valid && in_ready;
  assign in_wr    = (state_q == ST_WR);
  assign wr_ovf   = in_wr && hold_acc && (|lane_ovf);

  // State register; reset returns to IDLE and drops any row in flight.
  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    if (rstn) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state and OMEM port drive.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch.
    state_d = state_q;
    en_o    = 1'b0;
    rw_o    = OMEM_RD;
    addr_o  = '0;
    wdata_o = '0;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = in_acc ? ST_RD : ST_WR;
      ST_RD: begin
        en_o    = 1'b1;
        rw_o    = OMEM_RD;
        addr_o  = hold_addr;
        state_d = ST_WR;
      end
      ST_WR: begin
        en_o    = 1'b1;
        rw_o    = OMEM_WR;
        addr_o  = hold_addr;
        wdata_o = hold_acc ? sum_word : hold_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Holding registers for the accepted row.
  always_ff @(posedge clk or posedge rstn) begin
    // NOTE: these are plain registers, not a memory array, so they are
    // cleared on reset to keep the idle outputs deterministic.
    if (rstn) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_acc  <= 1'b0;
      hold_last <= 1'b0;
    end else if (accept) begin
      hold_addr <= in_addr;
      hold_data <= in_data;
      hold_acc  <= in_acc;
      hold_last <= in_last;
    end
  end

  // Tile bookkeeping: written-row count, end-of-tile pulse, sticky overflow.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wcnt <= '0;
      done <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      done <= in_wr && hold_last;
      if (in_wr) begin
        if (hold_last)               wcnt <= '0;
        else if (wcnt != {WCNT_W{1'b1}}) wcnt <= wcnt + 1'b1;
      end
      if (wr_ovf)                  ovf <= 1'b1;
      else if (accept && in_last)  ovf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_omem_acc_writer.sv
// Directed bench for omem_acc_writer: a wrap-mode and a saturating instance
// share stimulus, each backed by its own behavioural OMEM.
module tb_omem_acc_writer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [3:0]  in_addr;
  logic [63:0] in_data;
  logic        in_acc;
  logic        in_last;

  logic        in_ready, en0, rw0, done0, ovf0;
  logic [3:0]  addr0;
  logic [63:0] wdata0, rdata0;
  logic [4:0]  wcnt0;

  logic        in_ready_s, en1, rw1, done1, ovf1;
  logic [3:0]  addr1;
  logic [63:0] wdata1, rdata1;
  logic [4:0]  wcnt1;

  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [63:0] pre_data;
  logic [63:0] mem0 [16];
  logic [63:0] mem1 [16];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  omem_acc_writer #(.SAT(0)) u_dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_acc(in_acc), .in_last(in_last),
    .en_o(en0), .rw_o(rw0), .addr_o(addr0), .wdata_o(wdata0), .rdata_o(rdata0),
    .done(done0), .wcnt(wcnt0), .ovf(ovf0)
  );

  omem_acc_writer #(.SAT(1)) u_dut_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_addr(in_addr), .in_data(in_data), .in_acc(in_acc), .in_last(in_last),
    .en_o(en1), .rw_o(rw1), .addr_o(addr1), .wdata_o(wdata1), .rdata_o(rdata1),
    .done(done1), .wcnt(wcnt1), .ovf(ovf1)
  );

  // OMEM models: read data one cycle after request, preload port for setup.
  always @(posedge clk) begin
    if (pre_we) begin
      mem0[pre_addr] <= pre_data;
      mem1[pre_addr] <= pre_data;
    end else begin
      if (en0 && rw0) mem0[addr0] <= wdata0;
      if (en1 && rw1) mem1[addr1] <= wdata1;
    end
    if (en0 && !rw0) rdata0 <= mem0[addr0];
    if (en1 && !rw1) rdata1 <= mem1[addr1];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] a, input logic [63:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick();
    pre_we = 1'b0;
  endtask

  task automatic offer(input logic [3:0] a, input logic [63:0] d, input logic acc, input logic last);
    in_valid = 1'b1; in_addr = a; in_data = d; in_acc = acc; in_last = last;
  endtask

  initial begin
    rstn = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0;
    in_acc = 1'b0; in_last = 1'b0; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    rdata0 = '0; rdata1 = '0;
    #1;
    for (int i = 0; i < 16; i++) preload(4'(i), 64'h0);

    // Reset state
    check("rst in_ready", 64'(in_ready), 64'h0);
    check("rst en", 64'(en0), 64'h0);
    check("rst rw", 64'(rw0), 64'h0);
    check("rst addr", 64'(addr0), 64'h0);
    check("rst wdata", wdata0, 64'h0);
    check("rst done", 64'(done0), 64'h0);
    check("rst wcnt", 64'(wcnt0), 64'h0);
    check("rst ovf", 64'(ovf0), 64'h0);
    rstn = 1'b0;
    #1;
    check("ready after release", 64'(in_ready), 64'h1);
    tick();

    // Overwrite: write one cycle after acceptance, no read
    offer(4'd3, 64'h0004_0003_0002_0001, 1'b0, 1'b0);
    check("ow ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    check("ow en", 64'(en0), 64'h1);
    check("ow rw", 64'(rw0), 64'h1);
    check("ow addr", 64'(addr0), 64'h3);
    check("ow wdata", wdata0, 64'h0004_0003_0002_0001);
    tick();
    check("ow idle en", 64'(en0), 64'h0);
    check("ow mem", mem0[3], 64'h0004_0003_0002_0001);
    check("ow wcnt", 64'(wcnt0), 64'h1);

    // Accumulate: read then write sum
    preload(4'd5, 64'h0001_0001_0001_0001);
    offer(4'd5, 64'h0002_0002_0002_0002, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("acc rd en", 64'(en0), 64'h1);
    check("acc rd rw", 64'(rw0), 64'h0);
    check("acc rd addr", 64'(addr0), 64'h5);
    check("acc rd ready", 64'(in_ready), 64'h0);
    tick();
    check("acc wr rw", 64'(rw0), 64'h1);
    check("acc wr addr", 64'(addr0), 64'h5);
    check("acc wdata", wdata0, 64'h0003_0003_0003_0003);
    tick();
    check("acc idle en", 64'(en0), 64'h0);
    check("acc wcnt", 64'(wcnt0), 64'h2);

    // Overflow: lane0 positive overflow, lane1 negative overflow, lane2 none
    preload(4'd7, 64'h0000_7FFF_8000_7FFF);
    offer(4'd7, 64'h0000_8000_FFFF_0001, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    tick();
    check("ovf wrap wdata", wdata0, 64'h0000_FFFF_7FFF_8000);
    check("ovf sat wdata", wdata1, 64'h0000_FFFF_8000_7FFF);
    check("ovf not yet", 64'(ovf0), 64'h0);
    tick();
    check("ovf wrap flag", 64'(ovf0), 64'h1);
    check("ovf sat flag", 64'(ovf1), 64'h1);
    check("ovf wcnt", 64'(wcnt0), 64'h3);

    // Back-to-back accumulate rows to the same address
    offer(4'd2, 64'h0001_0001_0001_0001, 1'b1, 1'b0);
    tick();
    offer(4'd2, 64'h0002_0002_0002_0002, 1'b1, 1'b0);
    check("b2b held off", 64'(in_ready), 64'h0);
    tick();
    check("b2b first wdata", wdata0, 64'h0001_0001_0001_0001);
    tick();
    check("b2b second ready", 64'(in_ready), 64'h1);
    tick();
    in_valid = 1'b0;
    check("b2b second rd", 64'(rw0), 64'h0);
    check("b2b second addr", 64'(addr0), 64'h2);
    tick();
    check("b2b readback", rdata0, 64'h0001_0001_0001_0001);
    check("b2b final wdata", wdata0, 64'h0003_0003_0003_0003);
    tick();
    check("b2b mem", mem0[2], 64'h0003_0003_0003_0003);
    check("b2b wcnt", 64'(wcnt0), 64'h5);
    check("b2b ovf sticky", 64'(ovf0), 64'h1);

    // LAST row clears OVF on acceptance and the count in its WR
    offer(4'd9, 64'h0000_0000_0000_AAAA, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("last ovf cleared", 64'(ovf0), 64'h0);
    check("last wr wcnt", 64'(wcnt0), 64'h5);
    check("last wr done", 64'(done0), 64'h0);
    tick();
    check("last done", 64'(done0), 64'h1);
    check("last wcnt", 64'(wcnt0), 64'h0);
    tick();
    check("last done drop", 64'(done0), 64'h0);

    // Tile end: four rows, last with IN_LAST
    for (int i = 0; i < 4; i++) begin
      offer(4'(10 + i), 64'(i + 1), 1'b0, (i == 3));
      tick();
      in_valid = 1'b0;
      check("tile wr", 64'(rw0), 64'h1);
      tick();
      check("tile wcnt", 64'(wcnt0), (i == 3) ? 64'h0 : 64'(i + 1));
      check("tile done", 64'(done0), (i == 3) ? 64'h1 : 64'h0);
    end
    tick();
    check("tile done single", 64'(done0), 64'h0);

    // Reset during RD of an accumulate row
    preload(4'd4, 64'h1111_2222_3333_4444);
    offer(4'd4, 64'h0000_0000_0000_0001, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("abort in rd", 64'(en0), 64'h1);
    rstn = 1'b1;
    #1;
    check("abort en", 64'(en0), 64'h0);
    check("abort rw", 64'(rw0), 64'h0);
    check("abort addr", 64'(addr0), 64'h0);
    check("abort wdata", wdata0, 64'h0);
    check("abort ready", 64'(in_ready), 64'h0);
    check("abort wcnt", 64'(wcnt0), 64'h0);
    tick();
    check("abort en held", 64'(en0), 64'h0);
    rstn = 1'b0;
    #1;
    check("abort ready after", 64'(in_ready), 64'h1);
    tick();
    check("abort no replay", 64'(en0), 64'h0);
    check("abort mem kept", mem0[4], 64'h1111_2222_3333_4444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/omem_acc_writer.md
OMEM_ACC_WRITER -- requirements
Module: omem_acc_writer

Interface
REQ-001 Parameter LANES, default 4: 16-bit lanes per output word.
REQ-002 Parameter LANE_W, default 16: lane width in bits; word width is LANES*LANE_W (64).
REQ-003 Parameter SAT, default 0: 0 = wrap-around lane add, 1 = signed saturating lane add.
REQ-004 CLK  in  1  sole clock, all state on rising edge.
REQ-005 RSTN  in  1  asynchronous, active-high reset; the name is kept per the codebase, and the polarity is high.
REQ-006 IN_VALID  in  1  result row offered by output stage.
REQ-007 IN_READY  out  1  block accepts the row this cycle.
REQ-008 IN_ADDR  in  4  OMEM destination row.
REQ-009 IN_DATA  in  64  four 16-bit MAC lane results, lane0 = bits 15:0.
REQ-010 IN_ACC  in  1  1 = add to existing OMEM content, 0 = overwrite.
REQ-011 IN_LAST  in  1  row is the final row of the tile.
REQ-012 EN_O  out  1  OMEM enable.
REQ-013 RW_O  out  1  1 = write, 0 = read; meaningful only with EN_O=1.
REQ-014 ADDR_O  out  4  OMEM address.
REQ-015 WDATA_O  out  64  OMEM write data.
REQ-016 RDATA_O  in  64  OMEM read data, valid exactly one cycle after a read request.
REQ-017 DONE  out  1  one-cycle pulse after the IN_LAST row is written.
REQ-018 WCNT  out  5  rows written since the last DONE.
REQ-019 OVF  out  1  sticky: some lane overflowed (wrap) or clipped (sat) since the last accepted IN_LAST row.

Function
REQ-020 FSM states are IDLE, RD and WR; IN_READY=1 only in IDLE.
REQ-021 In IDLE, IN_VALID & IN_READY captures ADDR/DATA/ACC/LAST into holding registers; the next state is RD if ACC=1, else WR.
REQ-022 RD: EN_O=1, RW_O=0, ADDR_O=held addr; the next state is WR.
REQ-023 WR: EN_O=1, RW_O=1, ADDR_O=held addr; WDATA_O = lane-wise sum of RDATA_O and held data if ACC=1, else held data; the next state is IDLE.
REQ-024 Timing: a non-acc row writes 1 cycle after acceptance; an acc row writes 2 cycles after acceptance.
REQ-025 Back-to-back rows to the same address are hazard-free, because each write completes before the next row is accepted.
REQ-026 Lane add is a LANE_W-bit two's-complement add with no carry across lanes.
REQ-027 With SAT=1, a lane clips to +32767 / -32768 on signed overflow.
REQ-028 Overflow detection is the same for both modes: operands share a sign and the result sign differs.
REQ-029 OVF sets in any WR cycle with a lane overflow.
REQ-030 OVF clears on acceptance of a row whose held LAST=1; an overflow in that same row's WR sets OVF again.
REQ-031 WCNT increments in each WR cycle and saturates at 31.
REQ-032 In the WR cycle of a LAST row, WCNT clears to 0 instead of incrementing, and DONE pulses in the following cycle.
REQ-033 Outside RD/WR, EN_O=0, RW_O=0, ADDR_O=0 and WDATA_O=0.
REQ-034 IN_VALID with IN_READY=0 has no effect; the upstream holds the row until accepted.

Reset
REQ-035 While RSTN=1, the FSM is in IDLE and all holding registers are 0.
REQ-036 While RSTN=1, the outputs are: IN_READY=0, EN_O=0, RW_O=0, ADDR_O=0, WDATA_O=0, DONE=0, WCNT=0, OVF=0.
REQ-037 IN_READY rises in the first cycle after RSTN falls.
REQ-038 Reset asserted in RD or WR aborts the row with no write issued after assertion; the row is not replayed.

Structure
REQ-039 A shared package holds the state encoding (IDLE/RD/WR), the RW_O constants (OMEM_RD=0, OMEM_WR=1) and the LANE_W/LANES defaults.
REQ-040 Sub-module lane_add: one combinational lane adder with a SAT parameter and an overflow output, instantiated LANES times.
REQ-041 All other logic (FSM, holding registers, counters) is flat in omem_acc_writer.

Verification
REQ-042 Overwrite: row ADDR=3, DATA=0x0004_0003_0002_0001, ACC=0 -> one write to addr 3 with that data, 1 cycle after acceptance, and no read.
REQ-043 Accumulate: OMEM[5]=0x0001_0001_0001_0001; row ADDR=5, DATA=0x0002_0002_0002_0002, ACC=1 -> read addr 5, then write 0x0003_0003_0003_0003.
REQ-044 Overflow: lane0 old 0x7FFF plus 0x0001 -> with SAT=0, lane0 writes 0x8000 and OVF=1; with SAT=1, lane0 writes 0x7FFF and OVF=1.
REQ-045 Back-to-back same address: two ACC rows to addr 2 with DATA lanes 1 then 2 on zeroed OMEM -> final lanes 3, and the second read returns the first write.
REQ-046 Tile end: four rows, the last with IN_LAST=1 -> WCNT steps 1, 2, 3, then clears to 0 in the 4th WR; DONE pulses once the following cycle.
REQ-047 Reset in RD of an ACC row -> no write occurs, all outputs are 0, and IN_READY=1 the cycle after release.
